// File: rtl/pong_io_pkg.sv
// Shared constants and helpers for the Pong I/O register block.
// Page numbers decode iomem_addr[31:24].
package pong_io_pkg;

    localparam int POS_W = 10;

    localparam logic [7:0] PAGE_FIRST = 8'h03;
    localparam logic [7:0] PAGE_GPIO  = 8'h03;
    localparam logic [7:0] PAGE_PADL  = 8'h04;
    localparam logic [7:0] PAGE_PADR  = 8'h05;
    localparam logic [7:0] PAGE_BALLX = 8'h06;
    localparam logic [7:0] PAGE_BALLY = 8'h07;
    localparam logic [7:0] PAGE_BTN0  = 8'h08;
    localparam logic [7:0] PAGE_STAT  = 8'h0C;

    // Merge a byte-strobed write into a 10-bit position register.
    function automatic logic [POS_W-1:0] pos_merge(
        input logic [POS_W-1:0] cur,
        input logic [POS_W-1:0] wd,
        input logic [1:0]       be
    );
        logic [POS_W-1:0] r;
        r = cur;
        if (be[0]) r[7:0] = wd[7:0];
        if (be[1]) r[POS_W-1:8] = wd[POS_W-1:8];
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter,
// debounced level and a single-cycle rising-edge pulse.
module btn_debounce #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count cycles the synced input disagrees with the level; flip on LAST.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            level_d = s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser, counter and debounced level state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/pong_io_regfile.sv
// Pong I/O register block on the picosoc iomem bus: GPIO, switches,
// vsync-committed paddle/ball positions and sticky button events.
module pong_io_regfile
    import pong_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned PADDLE_RST       = 150,
    parameter int unsigned BALL_RST         = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic [15:0] sw,
    input  logic [3:0]  btn,
    input  logic        vsync,
    output logic [31:0] gpio,
    output logic [9:0]  paddle_left_pos,
    output logic [9:0]  paddle_right_pos,
    output logic [9:0]  ball_pos_x,
    output logic [9:0]  ball_pos_y
);

    localparam logic [POS_W-1:0] PR = POS_W'(PADDLE_RST);
    localparam logic [POS_W-1:0] BR = POS_W'(BALL_RST);
    localparam logic [3:0][POS_W-1:0] POS_RST = {BR, BR, PR, PR};

    // Index 0..3 = paddle_left, paddle_right, ball_x, ball_y.
    logic [3:0][POS_W-1:0] shadow_q, shadow_d;
    logic [3:0][POS_W-1:0] live_q, live_d;
    logic [31:0]           gpio_q, gpio_d;
    logic [15:0]           frame_q, frame_d;
    logic                  pending_q, pending_d;
    logic [3:0]            sticky_q, sticky_d;
    logic                  ready_q;
    logic [31:0]           rdata_q, rd_mux;
    logic                  vs1_q, vs2_q, vs_act_q;

    logic [7:0] page;
    logic [1:0] sel;
    logic       acc, rd, pos_hit, btn_hit, pos_we, gpio_we;
    logic       vs_act, commit;
    logic [3:0] deb, rise;
    logic       unused_addr;

    assign page        = iomem_addr[31:24];
    assign sel         = page[1:0];
    assign unused_addr = ^iomem_addr[23:0];

    // Pages below PAGE_FIRST belong to the SoC and are never acknowledged.
    assign acc     = iomem_valid & ~ready_q & (page >= PAGE_FIRST);
    assign rd      = acc & (iomem_wstrb == 4'b0000);
    assign pos_hit = (page[7:2] == PAGE_PADL[7:2]);
    assign btn_hit = (page[7:2] == PAGE_BTN0[7:2]);
    assign pos_we  = acc & pos_hit & (|iomem_wstrb[1:0]);
    assign gpio_we = acc & (page == PAGE_GPIO);

    // Assertion edge of the synchronised vsync starts a frame commit.
    assign vs_act = vs2_q ^ VSYNC_ACTIVE_LOW;
    assign commit = vs_act & ~vs_act_q;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_btn
            btn_debounce #(
                .CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk    (clk),
                .resetn (resetn),
                .btn_i  (btn[g]),
                .level_o(deb[g]),
                .rise_o (rise[g])
            );
        end
    endgenerate

    // Read data mux; sampled pre-update on the acknowledge edge.
    always_comb begin
        rd_mux = '0;
        if (page == PAGE_GPIO) begin
            rd_mux = {sw, gpio_q[15:0]};
        end else if (pos_hit) begin
            rd_mux = {{(32-POS_W){1'b0}}, shadow_q[sel]};
        end else if (btn_hit) begin
            rd_mux = {30'd0, sticky_q[sel], deb[sel]};
        end else if (page == PAGE_STAT) begin
            rd_mux = {pending_q, 15'd0, frame_q};
        end
    end

    // Register-file next state: commit first, then bus writes win.
    always_comb begin
        shadow_d  = shadow_q;
        live_d    = live_q;
        frame_d   = frame_q;
        pending_d = pending_q;
        gpio_d    = gpio_q;
        sticky_d  = sticky_q | rise;
        if (commit) begin
            live_d    = shadow_q;
            frame_d   = frame_q + 16'd1;
            pending_d = 1'b0;
        end
        if (pos_we) begin
            shadow_d[sel] = pos_merge(shadow_q[sel],
                                      iomem_wdata[POS_W-1:0],
                                      iomem_wstrb[1:0]);
            pending_d = 1'b1;
        end
        for (int b = 0; b < 4; b++) begin
            if (gpio_we && iomem_wstrb[b]) begin
                gpio_d[8*b +: 8] = iomem_wdata[8*b +: 8];
            end
        end
        if (rd && btn_hit) begin
            sticky_d[sel] = rise[sel];
        end
    end

    // Register-file and vsync synchroniser state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_q  <= POS_RST;
            live_q    <= POS_RST;
            frame_q   <= '0;
            pending_q <= 1'b0;
            gpio_q    <= '0;
            sticky_q  <= '0;
            vs1_q     <= VSYNC_ACTIVE_LOW;
            vs2_q     <= VSYNC_ACTIVE_LOW;
            vs_act_q  <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            live_q    <= live_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
            gpio_q    <= gpio_d;
            sticky_q  <= sticky_d;
            vs1_q     <= vsync;
            vs2_q     <= vs1_q;
            vs_act_q  <= vs_act;
        end
    end

    // Single-cycle acknowledge with registered read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= acc;
            rdata_q <= acc ? rd_mux : 32'd0;
        end
    end

    assign iomem_ready      = ready_q;
    assign iomem_rdata      = rdata_q;
    assign gpio             = gpio_q;
    assign paddle_left_pos  = live_q[0];
    assign paddle_right_pos = live_q[1];
    assign ball_pos_x       = live_q[2];
    assign ball_pos_y       = live_q[3];

endmodule

// File: tb/tb_pong_io_regfile.sv
// Scoreboard bench for pong_io_regfile: bus reads push expected
// rdata, a negedge monitor pops and compares on each acknowledge.
module tb_pong_io_regfile;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'd0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic [31:0] iomem_rdata;
    logic [15:0] sw = 16'hBEEF;
    logic [3:0]  btn = 4'd0;
    logic        vsync = 1'b1;
    logic [31:0] gpio;
    logic [9:0]  paddle_left_pos, paddle_right_pos;
    logic [9:0]  ball_pos_x, ball_pos_y;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          en;
        logic [31:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];

    pong_io_regfile #(
        .DEBOUNCE_CYCLES (16),
        .VSYNC_ACTIVE_LOW(1'b1),
        .PADDLE_RST      (150),
        .BALL_RST        (0)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .iomem_valid     (iomem_valid),
        .iomem_ready     (iomem_ready),
        .iomem_wstrb     (iomem_wstrb),
        .iomem_addr      (iomem_addr),
        .iomem_wdata     (iomem_wdata),
        .iomem_rdata     (iomem_rdata),
        .sw              (sw),
        .btn             (btn),
        .vsync           (vsync),
        .gpio            (gpio),
        .paddle_left_pos (paddle_left_pos),
        .paddle_right_pos(paddle_right_pos),
        .ball_pos_x      (ball_pos_x),
        .ball_pos_y      (ball_pos_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] live(input int i);
        case (i)
            0:       return paddle_left_pos;
            1:       return paddle_right_pos;
            2:       return ball_pos_x;
            default: return ball_pos_y;
        endcase
    endfunction

    // Monitor: every acknowledge pops one expected entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (resetn && iomem_ready) begin
            if (sb.size() == 0) begin
                check("unexpected ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                if (e.en) check(e.nm, iomem_rdata, e.v);
            end
        end
    end

    task automatic xfer(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input bit en,
                        input logic [31:0] exp, input string nm,
                        input bit hold);
        exp_t e;
        int   lat;
        bit   got;
        e.en = en;
        e.v  = exp;
        e.nm = nm;
        sb.push_back(e);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = wd;
        iomem_wstrb = ws;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (iomem_ready) got = 1'b1;
        end
        if (!got) begin
            void'(sb.pop_back());
            check({nm, " ack timeout"}, 32'd0, 32'd1);
        end
        if (hold) begin
            check({nm, " latency"}, lat, 32'd1);
            @(posedge clk);
            #1;
            check({nm, " pulse"}, {31'd0, iomem_ready}, 32'd0);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
    endtask

    task automatic vs_commit(input int idx, input logic [9:0] old_v,
                             input logic [9:0] new_v);
        @(negedge clk);
        vsync = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("commit pos%0d edge%0d", idx, k),
                  {22'd0, live(idx)},
                  {22'd0, (k == 3) ? new_v : old_v});
        end
    endtask

    task automatic vs_release();
        repeat (4) @(posedge clk);
        @(negedge clk);
        vsync = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        // 1: reset values and basic read timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check("rst ready", {31'd0, iomem_ready}, 32'd0);
        check("rst rdata", iomem_rdata, 32'd0);
        check("rst gpio", gpio, 32'd0);
        check("rst pads", {12'd0, paddle_left_pos, paddle_right_pos},
              {12'd0, 10'd150, 10'd150});
        check("rst balls", {12'd0, ball_pos_x, ball_pos_y}, 32'd0);
        xfer(32'h0400_0000, 0, 4'b0000, 1, 32'h96, "rd padl", 1);
        xfer(32'h0600_0000, 0, 4'b0000, 1, 32'h0, "rd ballx", 0);

        // 2: shadow write, then vsync commit
        xfer(32'h0400_0000, 32'h12C, 4'b0011, 0, 0, "wr padl", 0);
        xfer(32'h0700_0000, 32'h21, 4'b0011, 0, 0, "wr bally", 0);
        check("padl mid-frame", {22'd0, paddle_left_pos}, 32'd150);
        xfer(32'h0C00_0000, 0, 4'b0000, 1, 32'h8000_0000, "stat pend", 0);
        vs_commit(0, 10'd150, 10'd300);
        check("bally commit", {22'd0, ball_pos_y}, 32'h21);
        vs_release();
        xfer(32'h0C00_0000, 0, 4'b0000, 1, 32'h0000_0001, "stat f1", 0);

        // 3: shadow write on the commit cycle
        @(negedge clk);
        vsync = 1'b0;
        @(posedge clk);
        @(posedge clk);
        xfer(32'h0700_0000, 32'h50, 4'b0011, 0, 0, "wr race", 0);
        check("race live bally", {22'd0, ball_pos_y}, 32'h21);
        xfer(32'h0700_0000, 0, 4'b0000, 1, 32'h50, "race shadow", 0);
        xfer(32'h0C00_0000, 0, 4'b0000, 1, 32'h8000_0002, "stat race", 0);
        vs_release();
        vs_commit(3, 10'h21, 10'h50);
        vs_release();
        xfer(32'h0C00_0000, 0, 4'b0000, 1, 32'h0000_0003, "stat f3", 0);

        // 4: byte strobes on a position register
        xfer(32'h0600_0000, 32'h100, 4'b0011, 0, 0, "wr ballx", 0);
        xfer(32'h0600_0000, 32'hFFFF_FFFF, 4'b0001, 0, 0, "wr b0", 0);
        xfer(32'h0600_0000, 0, 4'b0000, 1, 32'h1FF, "ballx b0", 0);
        vs_commit(2, 10'd0, 10'h1FF);
        vs_release();
        xfer(32'h0600_0000, 32'h0, 4'b1100, 0, 0, "wr hi", 0);
        xfer(32'h0600_0000, 0, 4'b0000, 1, 32'h1FF, "ballx hi", 0);
        xfer(32'h0C00_0000, 0, 4'b0000, 1, 32'h0000_0004, "stat hi", 0);

        // GPIO byte writes and switch readback
        xfer(32'h0300_0000, 32'hA5A5_1234, 4'b1111, 0, 0, "wr gpio", 0);
        check("gpio full", gpio, 32'hA5A5_1234);
        xfer(32'h0300_0000, 32'hFFFF_FFFF, 4'b0100, 0, 0, "wr gpio b2", 0);
        check("gpio b2", gpio, 32'hA5FF_1234);
        xfer(32'h0300_0000, 0, 4'b0000, 1, 32'hBEEF_1234, "rd gpio", 0);

        // 5: button debounce and sticky
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            btn[0] = 1'b1;
            repeat (3) @(negedge clk);
            btn[0] = 1'b0;
            repeat (2) @(negedge clk);
        end
        xfer(32'h0800_0000, 0, 4'b0000, 1, 32'h0, "btn bounce", 0);
        @(negedge clk);
        btn[0] = 1'b1;
        repeat (20) @(posedge clk);
        xfer(32'h0800_0000, 0, 4'b0000, 1, 32'h3, "btn press", 0);
        xfer(32'h0800_0000, 0, 4'b0000, 1, 32'h1, "btn cleared", 0);
        xfer(32'h0900_0000, 0, 4'b0000, 1, 32'h0, "btn1 idle", 0);
        @(negedge clk);
        btn[0] = 1'b0;
        repeat (22) @(posedge clk);
        xfer(32'h0800_0000, 0, 4'b0000, 1, 32'h0, "btn released", 0);
        @(negedge clk);
        btn[0] = 1'b1;
        repeat (17) @(posedge clk);
        xfer(32'h0800_0000, 0, 4'b0000, 1, 32'h0, "btn race rd", 0);
        xfer(32'h0800_0000, 0, 4'b0000, 1, 32'h3, "btn race kept", 0);

        // 6: unmapped/high pages and reset mid-request
        xfer(32'h0D00_0000, 0, 4'b0000, 1, 32'h0, "rd 0x0D", 0);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0200_0000;
        seen = 1'b0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (iomem_ready) seen = 1'b1;
        end
        check("page 0x02 no ack", {31'd0, seen}, 32'd0);
        iomem_valid = 1'b0;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        @(posedge clk);
        #1;
        check("pre-rst ready", {31'd0, iomem_ready}, 32'd1);
        resetn = 1'b0;
        #1;
        check("async rst ready", {31'd0, iomem_ready}, 32'd0);
        check("async rst rdata", iomem_rdata, 32'd0);
        check("async rst gpio", gpio, 32'd0);
        check("async rst pads", {12'd0, paddle_left_pos, paddle_right_pos},
              {12'd0, 10'd150, 10'd150});
        check("async rst balls", {12'd0, ball_pos_x, ball_pos_y}, 32'd0);
        iomem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        xfer(32'h0400_0000, 0, 4'b0000, 1, 32'h96, "post-rst padl", 0);
        xfer(32'h0C00_0000, 0, 4'b0000, 1, 32'h0, "post-rst stat", 0);
        xfer(32'h0800_0000, 0, 4'b0000, 1, 32'h0, "post-rst btn", 0);

        repeat (2) @(posedge clk);
        check("scoreboard empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_io_regfile.md
Name: pong_io_regfile

Overview:
Memory-mapped register block on the picosoc iomem bus that owns all Pong game I/O: GPIO/LEDs, switches, paddle/ball positions and buttons.
- CPU writes to paddle/ball positions go to shadow registers. They are copied to the live registers driven to pong_game_renderer only at the start of vertical sync, so the renderer never sees a mid-frame (torn) update.
- Buttons are synchronised, debounced and latched as sticky "pressed" events that are cleared when the CPU reads them.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles before a debounced button level changes (10 ms at 100 MHz).
- VSYNC_ACTIVE_LOW, 1, polarity of the vsync input; the assertion edge triggers a commit.
- PADDLE_RST, 150, reset value of the shadow and live paddle positions.
- BALL_RST, 0, reset value of the shadow and live ball x/y positions.

Ports:
- clk  in  1  system clock (clk_bufg domain)
- resetn  in  1  asynchronous active-low reset
- iomem_valid  in  1  bus request
- iomem_ready  out  1  one-cycle acknowledge
- iomem_wstrb  in  4  byte write strobes; 0 means read
- iomem_addr  in  32  byte address; decode uses [31:24] only
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- sw  in  16  slide switches, already quasi-static
- btn  in  4  raw asynchronous pushbuttons
- vsync  in  1  VGA vsync, asynchronous to clk
- gpio  out  32  GPIO register; [15:0] drives the LEDs
- paddle_left_pos  out  10  live position
- paddle_right_pos  out  10  live position
- ball_pos_x  out  10  live position
- ball_pos_y  out  10  live position

Behaviour:
- Reset (async assert, sync release by the upstream reset counter):
  - iomem_ready=0, iomem_rdata=0, gpio=0.
  - Shadow and live paddles = PADDLE_RST; shadow and live balls = BALL_RST.
  - frame_cnt=0, pending=0, debounced and sticky button state = 0, vsync/btn synchronisers = deasserted level.
- Bus handshake:
  - When iomem_valid=1 and iomem_ready=0 and the page is mapped, iomem_ready=1 and iomem_rdata are registered on the next clk edge.
  - iomem_ready is a single-cycle pulse. Back-to-back requests are therefore acknowledged at most every 2nd cycle.
  - If iomem_valid drops before the acknowledge, no side effects occur (writes and read-clears happen only on the acknowledge edge).
- Address map (addr[31:24]):
  - 0x03 GPIO: rdata={sw, gpio[15:0]}; wstrb[n] writes gpio byte n.
  - 0x04–0x07: shadow paddle_left, paddle_right, ball_x, ball_y respectively. rdata={22'd0, shadow}. wstrb[0] writes bits [7:0], wstrb[1] writes bits [9:8]; wstrb[3:2] are ignored. Any write with a nonzero wstrb[1:0] sets pending.
  - 0x08–0x0B: button 0–3. rdata={30'd0, sticky, debounced}. A read (wstrb=0) clears that button's sticky bit; writes are acknowledged with no effect.
  - 0x0C status: rdata={pending, 15'd0, frame_cnt[15:0]}; read-only.
  - 0x0D–0xFF: acknowledged, rdata=0, writes dropped.
  - 0x00–0x02: never acknowledged; these pages belong to the SoC.
- Frame commit:
  - vsync passes through a 2-flop synchroniser followed by an edge detector on the assertion edge (polarity per VSYNC_ACTIVE_LOW).
  - On the commit cycle: all four live registers load their shadow values, frame_cnt increments (wraps 0xFFFF→0), and pending clears.
  - Latency: live outputs change on the 3rd clk edge after vsync is first sampled asserted.
  - No edge, no change; vsync held asserted commits once only.
- Shadow write coinciding with the commit cycle: the commit uses the pre-write shadow value, the shadow takes the new value, and pending ends the cycle set. Set wins over clear.
- Buttons:
  - 2-flop synchroniser per button, then a per-button counter. The counter resets whenever the synced input equals the debounced level.
  - Debounced level flips when the counter reaches DEBOUNCE_CYCLES-1.
  - A debounced rising edge sets sticky. If the rising edge and a read-clear occur in the same cycle, sticky stays set.
- Widths: positions are 10-bit unsigned with no clamping; the CPU is responsible for keeping values in range.

Decomposition:
- Package pong_io_pkg holds:
  - page constants PAGE_GPIO=8'h03, PAGE_PADL=8'h04, PAGE_PADR=8'h05, PAGE_BALLX=8'h06, PAGE_BALLY=8'h07, PAGE_BTN0=8'h08, PAGE_STAT=8'h0C, PAGE_FIRST=8'h03
  - POS_W=10
- One sub-module, btn_debounce (synchroniser, counter, debounced level, rising-edge pulse), instantiated 4 times.
- The sticky latches stay in the top level because they depend on the bus decode.

Test Plan:
1. Reset, then read 0x04000000 → ready pulses for exactly 1 cycle, one cycle after valid, with rdata=0x00000096. Read 0x06000000 → rdata=0.
2. Write 0x0400_0000 with wdata=0x12C, wstrb=0011, mid-frame → paddle_left_pos stays 150 and 0x0C reads pending=1. After a vsync assertion, paddle_left_pos=300 exactly 3 cycles later, pending=0 and frame_cnt=1.
3. Shadow write of 0x50 to 0x07 landing on the commit cycle → live ball_pos_y keeps its old value, shadow=0x50, pending=1. The next vsync commits 0x50.
4. Byte strobes: shadow ball_x=0x100, write wdata=0xFFFFFFFF with wstrb=0001 → shadow reads 0x1FF. With wstrb=1100 the shadow is unchanged and pending is not set.
5. Buttons with DEBOUNCE_CYCLES=16: a 5-cycle-period bounce on btn[0] → 0x08 reads 0. Hold high for 20 cycles → read returns 0b11, and a second read returns 0b01. A press coinciding with a read-clear leaves sticky=1.
6. Read 0x0D000000 → acknowledged with rdata=0. Read 0x02000000 → no ready within 16 cycles. Assert resetn=0 during a pending request → ready=0 immediately, and all outputs return to their reset values.
